// File: rtl/ctr_m.sv
// Memory-stage pipeline controller: E/M control register, DM strobes, request/ready stall FSM, M/W control register.
// Optional access timeout with sticky error flag is enabled by defining CTR_M_TIMEOUT_EN.
module ctr_m #(
  parameter int TIMEOUT = 16,
  parameter int TW      = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op_23,
  input  logic [5:0] func_23,
  input  logic       RegWr_E,
  input  logic [1:0] Tnew_E,
  input  logic       dm_ready,
  output logic       dm_req,
  output logic       MemWr,
  output logic       MemRd,
  output logic [1:0] WBsel,
  output logic       RegWr_M,
  output logic [1:0] Tnew_M,
  output logic       stall_m,
  output logic [5:0] op_34,
  output logic [5:0] func_34,
  output logic       RegWr_W,
  output logic       dm_err
);

  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2b;
  localparam logic [5:0] OP_JAL = 6'h03;

  typedef enum logic {RUN, WAIT} state_t;

  state_t     state, state_nxt;
  logic [5:0] op_p0, func_p0;
  logic       is_lw, is_sw, is_jal, mem_op;
  logic       timeout_hit, done, timed_out;

  assign is_lw  = (op_p0 == OP_LW);
  assign is_sw  = (op_p0 == OP_SW);
  assign is_jal = (op_p0 == OP_JAL);
  assign mem_op = is_lw | is_sw;

  assign dm_req  = mem_op;
  assign MemRd   = is_lw;
  assign MemWr   = is_sw;
  assign WBsel   = is_lw ? 2'b01 : (is_jal ? 2'b10 : 2'b00);

  // A forced completion behaves like dm_ready for the pipe, but the access is flagged.
  assign done      = dm_ready | timeout_hit;
  assign timed_out = mem_op & timeout_hit & ~dm_ready;
  assign stall_m   = mem_op & ~done;

`ifdef CTR_M_TIMEOUT_EN
  logic [TW-1:0] wait_cnt;

  assign timeout_hit = (state == WAIT) && (wait_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      dm_err   <= 1'b0;
    end else begin
      wait_cnt <= (state == WAIT) ? wait_cnt + TW'(1) : '0;
      if (timed_out)
        dm_err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign dm_err      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (mem_op && !dm_ready) state_nxt = WAIT;
      WAIT:    if (!mem_op || done)     state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // E/M boundary: held while the M instruction waits on memory
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_p0   <= '0;
      func_p0 <= '0;
      RegWr_M <= 1'b0;
      Tnew_M  <= 2'b00;
    end else if (!stall_m) begin
      op_p0   <= op_23;
      func_p0 <= func_23;
      RegWr_M <= RegWr_E;
      Tnew_M  <= (Tnew_E == 2'b00) ? 2'b00 : Tnew_E - 2'd1;
    end
  end

  // M/W boundary: bubble while stalled; a timed-out lw must not write the GPR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_34   <= '0;
      func_34 <= '0;
      RegWr_W <= 1'b0;
    end else if (stall_m) begin
      op_34   <= '0;
      func_34 <= '0;
      RegWr_W <= 1'b0;
    end else begin
      op_34   <= op_p0;
      func_34 <= func_p0;
      RegWr_W <= RegWr_M & ~(timed_out & is_lw);
    end
  end

endmodule

// File: tb/tb_ctr_m.sv
// Bench for ctr_m: directed vector table, reset/timeout sequences, and random traffic against an instruction-level model.
module tb_ctr_m;

  localparam int TIMEOUT = 16;
`ifdef CTR_M_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk, rst_n;
  logic [5:0] op_23, func_23;
  logic       RegWr_E, dm_ready;
  logic [1:0] Tnew_E;
  logic       dm_req, MemWr, MemRd, RegWr_M, stall_m, RegWr_W, dm_err;
  logic [1:0] WBsel, Tnew_M;
  logic [5:0] op_34, func_34;

  int n_cmp  = 0;
  int n_fail = 0;

  ctr_m #(.TIMEOUT(TIMEOUT), .TW(5)) dut (
    .clk(clk), .rst_n(rst_n), .op_23(op_23), .func_23(func_23),
    .RegWr_E(RegWr_E), .Tnew_E(Tnew_E), .dm_ready(dm_ready),
    .dm_req(dm_req), .MemWr(MemWr), .MemRd(MemRd), .WBsel(WBsel),
    .RegWr_M(RegWr_M), .Tnew_M(Tnew_M), .stall_m(stall_m),
    .op_34(op_34), .func_34(func_34), .RegWr_W(RegWr_W), .dm_err(dm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic rw,
                       input logic [1:0] tn, input logic rdy);
    op_23 = op; func_23 = fn; RegWr_E = rw; Tnew_E = tn; dm_ready = rdy;
  endtask

  typedef struct {
    logic [5:0] op; logic [5:0] fn; logic rw; logic [1:0] tn; logic rdy;
    logic stall; logic rwm; logic [1:0] tnewm; logic [1:0] wbsel;
    logic rd; logic wr; logic [5:0] op34; logic rww;
  } vec_t;

  vec_t tbl[13];

  // Instruction-level reference model
  logic [5:0] m_op, m_fn, w_op, w_fn;
  logic       m_rw, w_rw, err;
  logic [1:0] m_tn;
  int         waited;

  task automatic model_reset();
    m_op = 0; m_fn = 0; m_rw = 0; m_tn = 0; w_op = 0; w_fn = 0; w_rw = 0; err = 0; waited = 0;
  endtask

  task automatic model_check_and_step();
    bit lw, sw, mem, timed, stall;
    lw = (m_op == 6'h23);
    sw = (m_op == 6'h2b);
    mem = lw || sw;
    timed = mem && !dm_ready && TO_EN && (waited >= TIMEOUT);
    stall = mem && !dm_ready && !timed;
    chk("rnd_stall", stall_m, stall);
    chk("rnd_dm_req", dm_req, mem);
    chk("rnd_MemRd", MemRd, lw);
    chk("rnd_MemWr", MemWr, sw);
    chk("rnd_WBsel", WBsel, lw ? 2'd1 : (m_op == 6'h03) ? 2'd2 : 2'd0);
    chk("rnd_RegWr_M", RegWr_M, m_rw);
    chk("rnd_Tnew_M", Tnew_M, m_tn);
    chk("rnd_op_34", op_34, w_op);
    chk("rnd_func_34", func_34, w_fn);
    chk("rnd_RegWr_W", RegWr_W, w_rw);
    chk("rnd_dm_err", dm_err, err);
    if (stall) begin
      waited++;
      w_op = 0; w_fn = 0; w_rw = 0;
    end else begin
      w_op = m_op; w_fn = m_fn; w_rw = m_rw && !(timed && lw);
      if (timed) err = 1;
      m_op = op_23; m_fn = func_23; m_rw = RegWr_E;
      m_tn = (Tnew_E > 0) ? Tnew_E - 2'd1 : 2'd0;
      waited = 0;
    end
  endtask

  task automatic do_reset();
    drive(6'h0, 6'h0, 1'b0, 2'b00, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt;
    logic [5:0] ops[6];
    ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2b; ops[3] = 6'h03; ops[4] = 6'h0d; ops[5] = 6'h04;

    //           op     fn     rw  tn    rdy  stall rwm tnm wbs rd wr op34   rww
    tbl[0]  = '{6'h00, 6'h21, 1, 2'b01, 0,   0,   0,  0,  0,  0, 0, 6'h00, 0};
    tbl[1]  = '{6'h23, 6'h00, 1, 2'b10, 1,   0,   1,  0,  0,  0, 0, 6'h00, 0};
    tbl[2]  = '{6'h2b, 6'h00, 0, 2'b00, 1,   0,   1,  1,  1,  1, 0, 6'h00, 1};
    tbl[3]  = '{6'h03, 6'h00, 1, 2'b00, 0,   1,   0,  0,  0,  0, 1, 6'h23, 1};
    tbl[4]  = '{6'h03, 6'h00, 1, 2'b00, 0,   1,   0,  0,  0,  0, 1, 6'h00, 0};
    tbl[5]  = '{6'h03, 6'h00, 1, 2'b00, 0,   1,   0,  0,  0,  0, 1, 6'h00, 0};
    tbl[6]  = '{6'h03, 6'h00, 1, 2'b00, 1,   0,   0,  0,  0,  0, 1, 6'h00, 0};
    tbl[7]  = '{6'h23, 6'h00, 1, 2'b10, 1,   0,   1,  0,  2,  0, 0, 6'h2b, 0};
    tbl[8]  = '{6'h2b, 6'h00, 0, 2'b00, 0,   1,   1,  1,  1,  1, 0, 6'h03, 1};
    tbl[9]  = '{6'h2b, 6'h00, 0, 2'b00, 1,   0,   1,  1,  1,  1, 0, 6'h00, 0};
    tbl[10] = '{6'h00, 6'h21, 1, 2'b01, 0,   1,   0,  0,  0,  0, 1, 6'h23, 1};
    tbl[11] = '{6'h00, 6'h21, 1, 2'b01, 1,   0,   0,  0,  0,  0, 1, 6'h00, 0};
    tbl[12] = '{6'h00, 6'h00, 0, 2'b00, 0,   0,   1,  0,  0,  0, 0, 6'h2b, 0};

    rst_n = 1'b0;
    drive(6'h0, 6'h0, 1'b0, 2'b00, 1'b0);
    @(negedge clk);
    #2;
    chk("rst_stall", stall_m, 0);
    chk("rst_RegWr_M", RegWr_M, 0);
    chk("rst_op_34", op_34, 0);
    chk("rst_RegWr_W", RegWr_W, 0);
    chk("rst_dm_err", dm_err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].op, tbl[i].fn, tbl[i].rw, tbl[i].tn, tbl[i].rdy);
      #2;
      chk($sformatf("vec%0d_stall", i), stall_m, tbl[i].stall);
      chk($sformatf("vec%0d_RegWr_M", i), RegWr_M, tbl[i].rwm);
      chk($sformatf("vec%0d_Tnew_M", i), Tnew_M, tbl[i].tnewm);
      chk($sformatf("vec%0d_WBsel", i), WBsel, tbl[i].wbsel);
      chk($sformatf("vec%0d_MemRd", i), MemRd, tbl[i].rd);
      chk($sformatf("vec%0d_MemWr", i), MemWr, tbl[i].wr);
      chk($sformatf("vec%0d_dm_req", i), dm_req, tbl[i].rd | tbl[i].wr);
      chk($sformatf("vec%0d_op_34", i), op_34, tbl[i].op34);
      chk($sformatf("vec%0d_RegWr_W", i), RegWr_W, tbl[i].rww);
      @(negedge clk);
    end

    // Asynchronous reset while a load is waiting
    drive(6'h23, 6'h00, 1'b1, 2'b10, 1'b1);
    @(negedge clk);
    drive(6'h00, 6'h00, 1'b0, 2'b00, 1'b0);
    @(negedge clk);
    #1;
    chk("wait_stall_before_rst", stall_m, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_stall", stall_m, 0);
    chk("async_rst_dm_req", dm_req, 0);
    chk("async_rst_RegWr_M", RegWr_M, 0);
    chk("async_rst_op_34", op_34, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("post_rst_stall", stall_m, 0);
    @(negedge clk);

`ifdef CTR_M_TIMEOUT_EN
    do_reset();
    drive(6'h23, 6'h00, 1'b1, 2'b10, 1'b0);
    @(negedge clk);
    drive(6'h00, 6'h00, 1'b0, 2'b00, 1'b0);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      #2;
      if (!stall_m) break;
      cnt++;
      @(negedge clk);
    end
    chk("timeout_stall_cycles", 8'(cnt), 8'd16);
    @(negedge clk);
    #2;
    chk("timeout_dm_err", dm_err, 1);
    chk("timeout_op_34", op_34, 6'h23);
    chk("timeout_RegWr_W", RegWr_W, 0);
    @(negedge clk);
    #2;
    chk("timeout_dm_err_sticky", dm_err, 1);
    @(negedge clk);
`endif

    do_reset();
    model_reset();
    for (int n = 0; n < 600; n++) begin
      drive(ops[$urandom_range(0, 5)], 6'($urandom_range(0, 63)), 1'($urandom),
            2'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0));
      #2;
      model_check_and_step();
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
